sram_burst_master: RTL and testbench

//  Initiator side of the single-port sram interface (addr/we/dataIn/dataOut, 1-cycle registered read).

---
 rtl/sram_burst_master_pkg.sv | 6 +
 rtl/sram_burst_master_rd_buf.sv | 47 ++++
 rtl/sram_burst_master.sv | 107 ++++++++++
 tb/tb_sram_burst_master.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_master_pkg.sv
// sram_burst_master_pkg: shared FSM encoding and sram write-enable levels
package sram_burst_master_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;
    localparam logic MEM_WE_WRITE = 1'b0;
    localparam logic MEM_WE_READ  = 1'b1;
endpackage

// File: rtl/sram_burst_master_rd_buf.sv
// sram_rd_buf: 2-entry in-order FIFO holding {last, data} read beats
module sram_rd_buf #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         empty
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_q, rd_d, wr_q, wr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop  = pop && cnt_q != 2'd0;
        do_push = push && (cnt_q != 2'd2 || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d  = do_push ? ~wr_q : wr_q;
        rd_d  = do_pop ? ~rd_q : rd_q;
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign count    = cnt_q;
    assign empty    = cnt_q == 2'd0;
endmodule

// File: rtl/sram_burst_master.sv
// sram_burst_master: burst write/read initiator for a 1-cycle-latency single-port sram
module sram_burst_master
    import sram_burst_master_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [1:0]            buf_count;
    logic                  buf_empty;
    logic [DATA_WIDTH:0]   buf_data;
    logic                  wr_hs, issue, is_last;

    // A read is only issued when the buffer is guaranteed room for its data
    assign wr_hs   = state_q == S_WRITE && wr_valid;
    assign issue   = state_q == S_READ && (buf_count + 2'(inflight_q)) < 2'd2;
    assign is_last = cnt_q == LEN_WIDTH'(1);

    sram_rd_buf #(.W(DATA_WIDTH + 1)) u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, mem_dout}),
        .pop       (rd_valid && rd_ready),
        .pop_data  (buf_data),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue && is_last;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                ptr_d   = cmd_addr;
                cnt_d   = cmd_len;
                state_d = cmd_len == '0 ? S_DONE : cmd_write ? S_WRITE : S_READ;
            end
            S_WRITE, S_READ: if (wr_hs || issue) begin
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - LEN_WIDTH'(1);
                state_d = !is_last ? state_q : state_q == S_WRITE ? S_DONE : S_DRAIN;
            end
            S_DRAIN: if (buf_empty && !inflight_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset forces every output to its idle level even before state settles
    always_comb begin
        cmd_ready = !rst && state_q == S_IDLE;
        wr_ready  = !rst && state_q == S_WRITE;
        busy      = !rst && state_q != S_IDLE;
        done      = !rst && state_q == S_DONE;
        rd_valid  = !rst && !buf_empty;
        rd_data   = buf_data[DATA_WIDTH-1:0];
        rd_last   = rd_valid && buf_data[DATA_WIDTH];
        mem_we    = (!rst && wr_hs) ? MEM_WE_WRITE : MEM_WE_READ;
        mem_addr  = rst ? '0 : ptr_q;
        mem_din   = (!rst && state_q == S_WRITE) ? wr_data : '0;
    end
endmodule

// File: tb/tb_sram_burst_master.sv
// tb_sram_burst_master: vector table, corner sequences and random bursts against a memory model
module tb_sram_burst_master;
    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, cmd_write;
    logic [1:0] cmd_addr;
    logic [2:0] cmd_len;
    logic       wr_valid, wr_ready, rd_valid, rd_ready, rd_last, busy, done, mem_we;
    logic [1:0] wr_data, rd_data, mem_addr, mem_din, mem_dout;
    logic [1:0] sram [4];
    logic [1:0] em [4];
    int         tests = 0, fails = 0;
    int         we_low, done_cnt, done_cyc;
    logic [1:0] rq [$];
    bit         lq [$];

    typedef struct {
        bit          wr;
        logic [1:0]  a;
        logic [2:0]  n;
        logic [15:0] wd;
        int          mode;
        logic [15:0] exp_rd;
    } vec_t;

    sram_burst_master #(.DATA_WIDTH(2), .ADDR_WIDTH(2), .LEN_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) sram[i] <= 2'd0;
        end else if (mem_we == 1'b0) begin
            sram[mem_addr] <= mem_din;
        end
        mem_dout <= sram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // mode 0: always valid/ready, 1: random, 2: rd_ready low for 5 cycles, 3: wr_valid 1,0,0,1
    task automatic run_burst(input bit wr, input logic [1:0] a, input logic [2:0] n,
                             input logic [15:0] wd, input int mode);
        int beat = 0;
        we_low = 0; done_cnt = 0; done_cyc = -1;
        rq.delete(); lq.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = n;
        #1 chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            wr_valid = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 3 ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            rd_ready = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? (c >= 5) : 1'b1;
            wr_data  = wd[2*beat +: 2];
            #1;
            if (mode == 2 && c == 5) begin
                chk("stall_busy", busy, 1);
                chk("stall_rd_valid", rd_valid, 1);
                chk("stall_no_done", done_cnt, 0);
            end
            if (mem_we == 1'b0) we_low++;
            if (wr_valid && wr_ready) beat++;
            if (rd_valid && rd_ready) begin
                rq.push_back(rd_data);
                lq.push_back(rd_last);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        chk("burst_completed", done_cyc >= 0, 1);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic check_model(input bit wr, input logic [1:0] a, input logic [2:0] n,
                               input logic [15:0] wd);
        chk("done_pulses", done_cnt, 1);
        chk("we_low_cycles", we_low, wr ? n : 0);
        if (wr) begin
            for (int i = 0; i < n; i++) em[2'(a + i)] = wd[2*i +: 2];
            chk("write_no_rd", rq.size(), 0);
        end else begin
            chk("rd_beats", rq.size(), n);
            for (int i = 0; i < rq.size() && i < n; i++) begin
                chk("rd_data", rq[i], em[2'(a + i)]);
                chk("rd_last", lq[i], i == n - 1);
            end
        end
        for (int i = 0; i < 4; i++) chk("mem_content", sram[i], em[i]);
    endtask

    initial begin
        vec_t v [6];
        logic [15:0] got;
        int beats, dn, rv;
        v[0] = '{1'b1, 2'd1, 3'd3, 16'h001B, 0, 16'h0000};
        v[1] = '{1'b0, 2'd3, 3'd2, 16'h0000, 0, 16'h0001};
        v[2] = '{1'b1, 2'd0, 3'd2, 16'h0006, 3, 16'h0000};
        v[3] = '{1'b0, 2'd0, 3'd4, 16'h0000, 2, 16'h0066};
        v[4] = '{1'b0, 2'd2, 3'd0, 16'h0000, 0, 16'h0000};
        v[5] = '{1'b1, 2'd1, 3'd0, 16'hFFFF, 0, 16'h0000};
        for (int i = 0; i < 4; i++) em[i] = 2'd0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_mem_we", mem_we, 1);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_done", done, 0);

        foreach (v[k]) begin
            run_burst(v[k].wr, v[k].a, v[k].n, v[k].wd, v[k].mode);
            got = '0;
            for (int i = 0; i < rq.size() && i < 8; i++) got[2*i +: 2] = rq[i];
            chk("vec_rd_data", got, v[k].exp_rd);
            if (v[k].n == 0) chk("len0_done_cycle", done_cyc, 0);
            check_model(v[k].wr, v[k].a, v[k].n, v[k].wd);
        end

        // Reset in the middle of a read burst, after its first beat is taken
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_len = 3'd4; rd_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 20 && beats == 0; c++) begin
            #1;
            if (rd_valid && rd_ready) beats++;
            if (beats == 0) @(negedge clk);
        end
        chk("abort_first_beat", beats, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rst_rd_valid", rd_valid, 0);
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_done", done, 0);
        chk("abort_rst_cmd_ready", cmd_ready, 0);
        chk("abort_rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_rd_valid", rd_valid, 0);
        dn = 0; rv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            dn += int'(done);
            rv += int'(rd_valid);
        end
        chk("abort_no_done", dn, 0);
        chk("abort_no_rd_valid", rv, 0);
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) em[i] = 2'd0;

        for (int r = 0; r < 30; r++) begin
            bit          wr;
            logic [1:0]  a;
            logic [2:0]  n;
            logic [15:0] wd;
            wr = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            n  = 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            run_burst(wr, a, n, wd, 1);
            check_model(wr, a, n, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
